instruction_fetch: RTL and testbench

Program-counter and fetch-sequencing stage that sits directly upstream of `instruction_memory`. It owns the PC and drives the memory's word address. It tracks the one-cycle synchronous read in flight and buffers returned instructions in a 2-entry skid buffer. It delivers {instruction, PC} pairs to decode over a valid/ready handshake, and handles branch/jump redirects by flushing stale fetches.

---
 rtl/instruction_fetch_pkg.sv | 15 +
 rtl/instruction_fetch_skid_buffer.sv | 62 ++++++
 rtl/instruction_fetch.sv | 118 +++++++++++
 tb/tb_instruction_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg
// Shared definitions for the fetch stage: default reset vector, the NOP
// encoding shown on the outputs out of reset, and the fetch FSM encodings.
package instruction_fetch_pkg;

  localparam logic [31:0] IF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] IF_NOP          = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } if_state_t;

endpackage

// File: rtl/instruction_fetch_skid_buffer.sv
// fetch_skid_buffer
// Two-entry {instr, pc} FIFO between the instruction memory response and
// decode. Entry 0 is always the head. Flush empties the buffer and takes
// priority over push; a pop in the same cycle as a flush is harmless.
// Ports:
//   clk, reset          clock, async active-high reset
//   push, pushInstr/Pc  write a returned instruction with its PC
//   pop                 head entry consumed this cycle
//   flush               discard all entries
//   headInstr/headPc    head entry (NOP / 0 out of reset)
//   count               number of valid entries (0..2)
module fetch_skid_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DWIDTH-1:0] pushInstr,
  input  logic [DWIDTH-1:0] pushPc,
  input  logic              pop,
  input  logic              flush,
  output logic [DWIDTH-1:0] headInstr,
  output logic [DWIDTH-1:0] headPc,
  output logic [1:0]        count
);

  logic [DWIDTH-1:0] instr0, pc0, instr1, pc1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      instr0 <= DWIDTH'(IF_NOP);
      pc0    <= '0;
      instr1 <= DWIDTH'(IF_NOP);
      pc1    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (pop && count == 2'd2) begin
        instr0 <= instr1;
        pc0    <= pc1;
      end
      if (push) begin
        // New data lands in whichever slot becomes the tail after the pop.
        if (count == 2'd0 || (count == 2'd1 && pop)) begin
          instr0 <= pushInstr;
          pc0    <= pushPc;
        end else begin
          instr1 <= pushInstr;
          pc1    <= pushPc;
        end
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign headInstr = instr0;
  assign headPc    = pc0;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch
// Owns the PC, drives the instruction memory word address, tracks the single
// synchronous read in flight and hands {instr, pc} pairs to decode through a
// 2-entry skid buffer. Redirects flush the buffer and squash the in-flight read.
// Optional feature macro: IF_PERF_CNT_EN adds perfFetched / perfFlushed.
// Ports:
//   clk, reset                 clock, async active-high reset
//   fetchEnable                allow new fetches
//   memAddr / memData          word address out, instruction back one cycle later
//   redirectValid/redirectPc   branch/jump target (byte address, low bits ignored)
//   outValid/outReady          handshake to decode
//   outInstr/outPc             head instruction and its byte address
//   perfFetched/perfFlushed    (IF_PERF_CNT_EN) transfer and discard counters
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                DWIDTH       = 32,
  parameter logic [DWIDTH-1:0] RESET_VECTOR = DWIDTH'(IF_RESET_VECTOR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetchEnable,
  output logic [DWIDTH-1:0] memAddr,
  input  logic [DWIDTH-1:0] memData,
  input  logic              redirectValid,
  input  logic [DWIDTH-1:0] redirectPc,
  output logic              outValid,
  input  logic              outReady,
  output logic [DWIDTH-1:0] outInstr,
  output logic [DWIDTH-1:0] outPc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perfFetched,
  output logic [31:0]       perfFlushed
`endif
);

  if_state_t         state, nextState;
  logic [DWIDTH-1:0] pc, inflightPc, target, fetchPc;
  logic              inflight, issue, pop, push;
  logic [1:0]        bufCount;

  assign target = redirectPc & ~DWIDTH'(3);
  assign pop    = outValid && outReady;
  // A redirect squashes the read issued last cycle.
  assign push   = inflight && !redirectValid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_BOOT;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    issue     = 1'b0;
    fetchPc   = redirectValid ? target : pc;
    case (state)
      S_BOOT: nextState = S_RUN;
      S_RUN: begin
        if (!fetchEnable)
          nextState = S_HALT;
        else if (redirectValid)
          issue = 1'b1;
        // Occupancy after this cycle's pop must leave room for the new read.
        else if (({1'b0, bufCount} + {2'b00, inflight} - {2'b00, pop}) < 3'd2)
          issue = 1'b1;
      end
      S_HALT: if (fetchEnable) nextState = S_RUN;
      default: nextState = S_BOOT;
    endcase
    memAddr = fetchPc >> 2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_VECTOR;
      inflight   <= 1'b0;
      inflightPc <= '0;
    end else if (issue) begin
      pc         <= fetchPc + DWIDTH'(4);
      inflight   <= 1'b1;
      inflightPc <= fetchPc;
    end else begin
      inflight <= 1'b0;
      if (redirectValid) pc <= target;
    end
  end

  fetch_skid_buffer #(.DWIDTH(DWIDTH)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pushInstr (memData),
    .pushPc    (inflightPc),
    .pop       (pop),
    .flush     (redirectValid),
    .headInstr (outInstr),
    .headPc    (outPc),
    .count     (bufCount)
  );

  assign outValid = (bufCount != 2'd0);

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perfFetched <= '0;
      perfFlushed <= '0;
    end else begin
      if (pop) perfFetched <= perfFetched + 32'd1;
      if (redirectValid) perfFlushed <= perfFlushed + 32'(bufCount) + 32'(inflight);
    end
  end
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk, reset, fetchEnable, redirectValid, outValid, outReady;
  logic [31:0] memAddr, memData, redirectPc, outInstr, outPc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perfFetched, perfFlushed;
`endif

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic [31:0] expq[$];

  instruction_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .fetchEnable   (fetchEnable),
    .memAddr       (memAddr),
    .memData       (memData),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .outValid      (outValid),
    .outReady      (outReady),
    .outInstr      (outInstr),
    .outPc         (outPc)
`ifdef IF_PERF_CNT_EN
    ,
    .perfFetched   (perfFetched),
    .perfFlushed   (perfFlushed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Synchronous-read instruction memory model.
  initial memData = 32'h0;
  always @(posedge clk) memData <= memword(memAddr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic reload(input logic [31:0] start);
    expq.delete();
    for (int i = 0; i < 64; i++) expq.push_back(start + 32'(4 * i));
  endtask

  // Scoreboard: reset/redirect stimulus loads the expected PC stream,
  // every transfer pops and compares.
  always @(negedge clk) begin
    if (reset) begin
      reload(32'h0);
    end else begin
      if (outValid && outReady) begin
        if (expq.size() == 0) check("xfer_extra", 32'd1, 32'd0);
        else begin
          check("xfer_pc", outPc, expq[0]);
          check("xfer_instr", outInstr, memword(expq[0] >> 2));
          void'(expq.pop_front());
        end
        xfers++;
      end
      if (redirectValid) reload(redirectPc & 32'hFFFF_FFFC);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic boot_check();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("boot_idle", {31'b0, outValid}, 32'd0);
      if (c == 2) check("boot_addr", memAddr, 32'd1);
      cyc();
    end
    @(negedge clk);
    check("first_valid", {31'b0, outValid}, 32'd1);
    check("first_pc", outPc, 32'h0);
    cyc();
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!outValid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check(tag, {31'b0, outValid}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic [31:0] hp;
    reset = 1'b1; fetchEnable = 1'b1; outReady = 1'b1;
    redirectValid = 1'b0; redirectPc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, outValid}, 32'd0);
    check("rst_instr", outInstr, 32'h0000_0013);
    check("rst_pc", outPc, 32'h0);
    check("rst_addr", memAddr, 32'h0);
    reset = 1'b0;
    boot_check();

    // Steady state throughput.
    n0 = xfers;
    repeat (10) cyc();
    check("throughput", 32'(xfers - n0), 32'd10);

    // Backpressure: outputs and address hold, nothing issues.
    outReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, outValid}, 32'd1);
      check("stall_pc", outPc, expq[0]);
      check("stall_addr", memAddr, (expq[0] + 32'd8) >> 2);
      cyc();
    end

    // Redirect with two entries buffered, misaligned target.
    redirectValid = 1'b1; redirectPc = 32'h43;
    @(negedge clk);
    check("redir_addr", memAddr, 32'h10);
    cyc();
    redirectValid = 1'b0; outReady = 1'b1;
    @(negedge clk);
    check("redir_gap", {31'b0, outValid}, 32'd0);
    cyc();
    @(negedge clk);
    check("redir_valid", {31'b0, outValid}, 32'd1);
    check("redir_pc", outPc, 32'h40);
    cyc();
    repeat (5) cyc();

    // Redirect coinciding with a pop.
    n0 = xfers;
    redirectValid = 1'b1; redirectPc = 32'h80;
    @(negedge clk);
    check("rpop_valid", {31'b0, outValid}, 32'd1);
    cyc();
    redirectValid = 1'b0;
    @(negedge clk);
    check("rpop_gap", {31'b0, outValid}, 32'd0);
    cyc();
    check("rpop_once", 32'(xfers - n0), 32'd1);
    @(negedge clk);
    check("rpop_pc", outPc, 32'h80);
    cyc();
    repeat (4) cyc();

    // Halt: buffered and in-flight words drain, then silence.
    n0 = xfers;
    hp = expq[0];
    fetchEnable = 1'b0;
    repeat (6) cyc();
    check("halt_drain", 32'(xfers - n0), 32'd2);
    @(negedge clk);
    check("halt_idle", {31'b0, outValid}, 32'd0);
    check("halt_addr", memAddr, (hp + 32'd8) >> 2);
    cyc();
    redirectValid = 1'b1; redirectPc = 32'h100;
    @(negedge clk);
    check("hredir_addr", memAddr, 32'h40);
    cyc();
    redirectValid = 1'b0; fetchEnable = 1'b1;
    wait_valid("resume_valid");
    check("resume_pc", outPc, 32'h100);
    cyc();
    repeat (5) cyc();

    // Asynchronous reset mid-stream.
    reset = 1'b1;
    #1;
    check("arst_valid", {31'b0, outValid}, 32'd0);
    check("arst_addr", memAddr, 32'h0);
    check("arst_instr", outInstr, 32'h0000_0013);
    cyc();
    reset = 1'b0;
    boot_check();
    n0 = xfers;
    repeat (8) cyc();
    check("restart_rate", 32'(xfers - n0), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
